// File: rtl/high_score_table.sv
// ---------------------------------------------------------------------------
// high_score_table
//   Leaderboard that keeps the best DEPTH scores in descending order. A
//   finished game's score is offered with a one-cycle strobe. The block then
//   walks the table over a fixed sequence (SCAN -> SHIFT -> WRITE), so every
//   accepted insert completes the same number of cycles after the strobe,
//   whatever its rank.
//
// Handshake: i_score_valid is a single-cycle offer with no ready/back-pressure.
//   An offer is taken only while o_busy is low. An offer made while o_busy is
//   high is discarded, and o_dropped pulses on the following cycle.
//
// Ports
//   i_clk          system clock
//   i_reset        asynchronous, active-high; clears table and all state
//   i_clear_table  synchronous clear of all entries (IDLE only)
//   i_score_in     score offered by the game logic
//   i_score_valid  one-cycle strobe qualifying i_score_in
//   i_rd_index     table entry to read (0 = best)
//   o_rd_score     registered entry[i_rd_index]; 0 for out-of-range index
//   o_best_score   entry[0], straight from the table register
//   o_busy         state is not IDLE
//   o_insert_done  one-cycle pulse: table update now visible
//   o_insert_rank  rank of the last inserted score, held
//   o_reject       one-cycle pulse: score did not qualify
//   o_dropped      one-cycle pulse: strobe arrived while busy
//   o_state        current FSM state (debug)
// ---------------------------------------------------------------------------
module high_score_table #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int IDX_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear_table,
    input  logic [WIDTH-1:0] i_score_in,
    input  logic             i_score_valid,
    input  logic [IDX_W-1:0] i_rd_index,
    output logic [WIDTH-1:0] o_rd_score,
    output logic [WIDTH-1:0] o_best_score,
    output logic             o_busy,
    output logic             o_insert_done,
    output logic [IDX_W-1:0] o_insert_rank,
    output logic             o_reject,
    output logic             o_dropped,
    output logic [1:0]       o_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    logic [WIDTH-1:0] r_entry [DEPTH];
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_score;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_pos;
    logic [IDX_W-1:0] r_rank;
    logic [WIDTH-1:0] r_rd_score;
    logic             r_insert_done;
    logic             r_reject;
    logic             r_dropped;

    logic [WIDTH-1:0] w_rd_val;

    // Read mux; indices with no backing entry return zero.
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_rd_index == k[IDX_W-1:0]) begin
                w_rd_val = r_entry[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_entry[k] <= '0;
            end
            r_state       <= S_IDLE;
            r_score       <= '0;
            r_i           <= '0;
            r_j           <= '0;
            r_pos         <= '0;
            r_rank        <= '0;
            r_rd_score    <= '0;
            r_insert_done <= 1'b0;
            r_reject      <= 1'b0;
            r_dropped     <= 1'b0;
        end else begin
            r_insert_done <= 1'b0;
            r_reject      <= 1'b0;
            r_dropped     <= 1'b0;
            r_rd_score    <= w_rd_val;

            if ((r_state != S_IDLE) && i_score_valid) begin
                r_dropped <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // Clear has priority; a coincident score is silently discarded.
                    if (i_clear_table) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            r_entry[k] <= '0;
                        end
                    end else if (i_score_valid) begin
                        r_score <= i_score_in;
                        r_i     <= '0;
                        r_state <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    // Strict compare: ties rank below the existing entry.
                    if (r_score > r_entry[r_i]) begin
                        r_pos <= r_i;
                        r_j   <= LAST;
                        r_state <= (r_i == LAST) ? S_WRITE : S_SHIFT;
                    end else if (r_i == LAST) begin
                        r_reject <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_i <= r_i + ONE;
                    end
                end

                S_SHIFT: begin
                    // Move one entry down per cycle from the bottom up; the old
                    // last entry falls off. SCAN + SHIFT together always take
                    // DEPTH cycles, which keeps insert latency rank-independent.
                    r_entry[r_j] <= r_entry[r_j - ONE];
                    r_j          <= r_j - ONE;
                    if ((r_j - ONE) == r_pos) begin
                        r_state <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    r_entry[r_pos] <= r_score;
                    r_rank         <= r_pos;
                    r_insert_done  <= 1'b1;
                    r_state        <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_score    = r_rd_score;
    assign o_best_score  = r_entry[0];
    assign o_busy        = (r_state != S_IDLE);
    assign o_insert_done = r_insert_done;
    assign o_insert_rank = r_rank;
    assign o_reject      = r_reject;
    assign o_dropped     = r_dropped;
    assign o_state       = r_state;

endmodule
